seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle RV32I ALU.
- Executes all base integer ops plus RV32M multiply/divide/remainder.
- Base ops use a registered 1-cycle path; M ops use an iterative radix-2 engine.
- Sits in the execute stage of the upcoming multi-cycle core, with valid/ready handshakes on both sides and branch compare flags.

Parameters:
XLEN, 32, operand/result width; power of two, >= 8.
SHW, $clog2(XLEN), shift-amount width (derived, not overridable).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  abort any in-flight op, discard held result
in_valid  in  1  operands/op valid
in_ready  out  1  block can accept
op  in  5  operation code (see Behaviour)
a  in  XLEN  operand A (rs1)
b  in  XLEN  operand B (rs2/imm)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  operation result
eq  out  1  a == b, captured at accept
lt  out  1  signed a < b, captured at accept
ltu  out  1  unsigned a < b, captured at accept
illegal  out  1  op code undefined; result forced to 0

Behaviour:
- Op codes:
  - Base: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLT 00101, SLL 00110, SRL 00111, SRA 01000, SLTU 01001.
  - M ops: MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
  - All other codes are illegal.
- Shifts use b[SHW-1:0]. Add/sub wrap modulo 2^XLEN. Flags come from a single XLEN+1-bit a + ~b + 1 subtractor: lt = N^V, ltu = ~carry, eq = (difference == 0).
- Acceptance: a transfer occurs on a rising edge with in_valid && in_ready && !flush. in_ready = (state==IDLE) || (state==DONE && out_ready).
- States:
  - IDLE: on accept, a base/illegal op or M-op special case → DONE; otherwise MUL → MULBUSY, DIV/REM → DIVBUSY.
  - MULBUSY: shift-add on operand magnitudes, one bit per cycle, XLEN iterations; counter reaches 0 → DONE.
  - DIVBUSY: restoring divide on magnitudes, one quotient bit per cycle, XLEN iterations → DONE.
  - DONE: out_valid=1. With out_ready=1: go to IDLE, or take a new op directly if one is offered.
- Latency, accept edge to out_valid high:
  - Base ops, illegal ops and special cases: 1 edge.
  - Iterative M ops: exactly XLEN+1 edges.
  - Sign correction (negate product/quotient/remainder) happens on the final iteration edge, so result is registered when out_valid rises.
- MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN-bit product; MUL returns the low bits. MULHSU treats a as signed and b as unsigned.
- Special cases, resolved at accept with 1-edge latency:
  - b==0: DIV/DIVU → all ones; REM/REMU → a.
  - DIV with a == most-negative and b == -1 → most-negative; REM for the same operands → 0.
- While out_valid && !out_ready: result, eq, lt, ltu and illegal are held stable. Changes on op/a/b are ignored.
- flush: synchronous. Next edge forces IDLE and out_valid=0, and cancels any same-cycle accept (flush wins). No partial result is ever presented.
- Reset (async, any state, including mid-iteration): state=IDLE, out_valid=0, result=0, eq=0, lt=0, ltu=0, illegal=0, counter=0. in_ready=1 once rst_n deasserts.
- No combinational path from op/a/b to result. in_ready depends only on state and out_ready.

Decomposition:
- Package seq_alu_pkg:
  - op code localparams / enum alu_op_e.
  - State enum alu_state_e.
  - Helper function is_mdu_op(op).
- One sub-module: seq_alu_mdu.
  - Holds the iterative mul/div datapath: counter, accumulator/remainder and operand shift registers, sign-fix logic.
  - Signals: start/busy/done toward the top-level FSM.
  - Top level holds the handshake FSM, base-op logic and flags.

Test Plan:
1. Base ops, XLEN=32: a=0xFFFFFFF0, b=0x4.
   - ADD → 0xFFFFFFF4, eq=0, lt=1, ltu=0.
   - SRA → 0xFFFFFFFF; SRL → 0x0FFFFFFF.
   - out_valid exactly 1 edge after accept.
2. MULH a=0x80000000, b=0x80000000 → 0x40000000; MULHU on the same operands → 0x40000000.
   - MUL a=-3, b=7 → 0xFFFFFFEB.
   - out_valid exactly 33 edges after accept.
3. Division, signed:
   - DIV a=-7, b=2 → 0xFFFFFFFD; REM a=-7, b=2 → 0xFFFFFFFF (both 33 edges).
   - DIV a=0x80000000, b=-1 → 0x80000000 after 1 edge.
4. Division by zero, all after 1 edge:
   - DIVU a=5, b=0 → 0xFFFFFFFF.
   - REMU a=5, b=0 → 5.
   - op=11111 → illegal=1, result=0.
5. Backpressure: hold out_ready=0 for 5 cycles after a MUL completes → result and flags stable, in_ready=0.
   - Then assert out_ready with a queued ADD offered → ADD accepted the same edge; its result appears 1 edge later.
6. Abort/reset:
   - Assert flush mid-DIV (iteration 10) together with in_valid → no accept, out_valid=0, IDLE next edge.
   - Repeat with rst_n pulsed low mid-MUL → all outputs 0 immediately, in_ready=1 after release.
   - Rerun with XLEN=16: MUL 300*300 → 0x5F90 after 17 edges.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared op codes, FSM state encoding and decode helpers for the
// sequential RV32IM ALU (seq_alu) and its iterative mul/div engine.
package seq_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'b00000,
    OP_SUB    = 5'b00001,
    OP_AND    = 5'b00010,
    OP_OR     = 5'b00011,
    OP_XOR    = 5'b00100,
    OP_SLT    = 5'b00101,
    OP_SLL    = 5'b00110,
    OP_SRL    = 5'b00111,
    OP_SRA    = 5'b01000,
    OP_SLTU   = 5'b01001,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MULBUSY = 2'b01,
    DIVBUSY = 2'b10,
    DONE    = 2'b11
  } alu_state_e;

  // All 10xxx codes are multiply/divide/remainder.
  function automatic logic is_mdu_op(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  // Base ops occupy the contiguous range 0..9.
  function automatic logic is_base_op(input logic [4:0] op);
    return op < 5'd10;
  endfunction

endpackage

// File: rtl/seq_alu_mdu.sv
// seq_alu_mdu: iterative radix-2 multiply / restoring divide engine.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           abort the current operation
//   start           load operands and begin (op = low 3 bits of the M op code)
//   a, b            operands, sampled on start
//   busy            an operation is iterating
//   done            this cycle's edge performs the final iteration
//   result          sign-corrected final value, valid while done is high
module seq_alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] acc_q, acc_d;    // product high half / partial remainder
  logic [XLEN-1:0] sh_q, sh_d;      // multiplier then product low half / dividend then quotient
  logic [XLEN-1:0] opnd_q, opnd_d;  // multiplicand / divisor magnitude
  logic            div_q, div_d;
  logic            hi_q, hi_d;      // mul: return high half; div: return remainder
  logic            neg_q, neg_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_rs, div_diff;
  logic [XLEN-1:0] acc_n, sh_n, div_val;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    // Operand signedness: DIV/REM signed, MUL/MULH both signed, MULHSU a only.
    a_neg = a[XLEN-1] & (op[2] ? ~op[0] : (op[1:0] != 2'b11));
    b_neg = b[XLEN-1] & (op[2] ? ~op[0] : ~op[1]);
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
    div_rs   = {acc_q, sh_q[XLEN-1]};
    div_diff = div_rs - {1'b0, opnd_q};
    if (div_q) begin
      if (!div_diff[XLEN]) begin
        acc_n = div_diff[XLEN-1:0];
        sh_n  = {sh_q[XLEN-2:0], 1'b1};
      end else begin
        acc_n = div_rs[XLEN-1:0];
        sh_n  = {sh_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_n = mul_sum[XLEN:1];
      sh_n  = {mul_sum[0], sh_q[XLEN-1:1]};
    end

    // Sign fix is applied to the values produced by the final iteration.
    prod    = {acc_n, sh_n};
    prod    = neg_q ? -prod : prod;
    div_val = hi_q ? acc_n : sh_n;
    div_val = neg_q ? -div_val : div_val;
    if (div_q) result = div_val;
    else       result = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    acc_d  = acc_q;
    sh_d   = sh_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    hi_d   = hi_q;
    neg_d  = neg_q;
    if (flush) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(XLEN);
      acc_d  = '0;
      div_d  = op[2];
      if (op[2]) begin
        sh_d   = a_mag;
        opnd_d = b_mag;
        hi_d   = op[1];
        neg_d  = op[1] ? a_neg : (a_neg ^ b_neg);
      end else begin
        sh_d   = b_mag;
        opnd_d = a_mag;
        hi_d   = op[1:0] != 2'b00;
        neg_d  = a_neg ^ b_neg;
      end
    end else if (busy_q) begin
      acc_d = acc_n;
      sh_d  = sh_n;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      acc_q  <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      hi_q   <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      hi_q   <= hi_d;
      neg_q  <= neg_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle RV32IM execute-stage ALU with valid/ready handshakes.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 abort in-flight op and drop any held result
//   in_valid/in_ready     operand handshake (op, a, b)
//   out_valid/out_ready   result handshake (result, eq, lt, ltu, illegal)
//   eq/lt/ltu             a==b, signed a<b, unsigned a<b captured at accept
//   illegal               op code undefined, result forced to 0
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            eq,
  output logic            lt,
  output logic            ltu,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d, illegal_q, illegal_d;

  logic            accept, op_legal, spec_hit, mdu_start, mdu_busy, mdu_done;
  logic [XLEN:0]   sub_ext;
  logic [XLEN-1:0] diff, base_res, spec_res, mdu_res;
  logic [SHW-1:0]  shamt;
  logic            ovf, flag_eq, flag_lt, flag_ltu;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign op_legal  = is_base_op(op) || is_mdu_op(op);

  // Single subtractor feeds SUB and all three compare flags.
  assign sub_ext  = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
  assign diff     = sub_ext[XLEN-1:0];
  assign ovf      = (a[XLEN-1] ^ b[XLEN-1]) & (diff[XLEN-1] ^ a[XLEN-1]);
  assign flag_lt  = diff[XLEN-1] ^ ovf;
  assign flag_ltu = ~sub_ext[XLEN];
  assign flag_eq  = (diff == '0);
  assign shamt    = b[SHW-1:0];

  always_comb begin
    base_res = '0;
    case (alu_op_e'(op))
      OP_ADD:  base_res = a + b;
      OP_SUB:  base_res = diff;
      OP_AND:  base_res = a & b;
      OP_OR:   base_res = a | b;
      OP_XOR:  base_res = a ^ b;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, flag_lt};
      OP_SLL:  base_res = a << shamt;
      OP_SRL:  base_res = a >> shamt;
      OP_SRA:  base_res = $signed(a) >>> shamt;
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, flag_ltu};
      default: base_res = '0;
    endcase
  end

  // Divide-by-zero and signed overflow resolve at accept without iterating.
  always_comb begin
    spec_hit = 1'b0;
    spec_res = '0;
    if (is_mdu_op(op) && op[2]) begin
      if (b == '0) begin
        spec_hit = 1'b1;
        spec_res = op[1] ? a : '1;
      end else if (!op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
        spec_hit = 1'b1;
        spec_res = op[1] ? '0 : a;
      end
    end
  end

  assign mdu_start = accept && is_mdu_op(op) && !spec_hit;

  seq_alu_mdu #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (mdu_start),
    .op     (op[2:0]),
    .a      (a),
    .b      (b),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .result (mdu_res)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    ltu_d     = ltu_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      eq_d      = flag_eq;
      lt_d      = flag_lt;
      ltu_d     = flag_ltu;
      illegal_d = !op_legal;
      if (!op_legal) begin
        result_d = '0;
        state_d  = DONE;
      end else if (mdu_start) begin
        state_d = op[2] ? DIVBUSY : MULBUSY;
      end else if (spec_hit) begin
        result_d = spec_res;
        state_d  = DONE;
      end else begin
        result_d = base_res;
        state_d  = DONE;
      end
    end else begin
      case (state_q)
        MULBUSY, DIVBUSY: begin
          if (mdu_busy && mdu_done) begin
            result_d = mdu_res;
            state_d  = DONE;
          end
        end
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      ltu_q     <= ltu_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector bench for seq_alu with a behavioural reference
// model (64-bit integer arithmetic) and a per-cycle output compare process.
`timescale 1ns/1ps
module tb_seq_alu;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, AND_ = 5'b00010, OR_ = 5'b00011;
  localparam logic [4:0] XOR_ = 5'b00100, SLT = 5'b00101, SLL = 5'b00110, SRL = 5'b00111;
  localparam logic [4:0] SRA = 5'b01000, SLTU = 5'b01001, MUL = 5'b10000, MULH = 5'b10001;
  localparam logic [4:0] MULHSU = 5'b10010, MULHU = 5'b10011, DIV = 5'b10100, DIVU = 5'b10101;
  localparam logic [4:0] REM = 5'b10110, REMU = 5'b10111;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  op;
  logic [31:0] a, b, result;
  logic eq, lt, ltu, illegal;

  logic s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [4:0]  s_op;
  logic [15:0] s_a, s_b, s_result;
  logic s_eq, s_lt, s_ltu, s_illegal;

  always #5 clk = ~clk;

  seq_alu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .eq(eq), .lt(lt), .ltu(ltu), .illegal(illegal));

  seq_alu #(.XLEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .op(s_op), .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
    .eq(s_eq), .lt(s_lt), .ltu(s_ltu), .illegal(s_illegal));

  typedef struct {
    logic [31:0] res;
    logic        eq, lt, ltu, ill;
    int          lat;
    int          acc_edge;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, res;
    int          lat;
    logic [3:0]  fl;  // {eq, lt, ltu, illegal}
  } vec_t;

  exp_t exp_q[$];
  vec_t vq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   edges = 0;
  bit   seen = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx, sy;
    longint unsigned ux, uy;
    logic [63:0] r;
    bit hi;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    r = '0; hi = 1'b0;
    e.lat = 1; e.ill = 1'b0; e.acc_edge = 0;
    e.eq = (x == y); e.lt = (sx < sy); e.ltu = (x < y);
    case (o)
      ADD:    r = ux + uy;
      SUB:    r = ux - uy;
      AND_:   r = ux & uy;
      OR_:    r = ux | uy;
      XOR_:   r = ux ^ uy;
      SLT:    r = {63'b0, sx < sy};
      SLL:    r = {32'b0, x << y[4:0]};
      SRL:    r = {32'b0, x >> y[4:0]};
      SRA:    r = sx >>> y[4:0];
      SLTU:   r = {63'b0, x < y};
      MUL:    begin r = sx * sy; e.lat = 33; end
      MULH:   begin r = sx * sy; hi = 1'b1; e.lat = 33; end
      MULHSU: begin r = sx * longint'(uy); hi = 1'b1; e.lat = 33; end
      MULHU:  begin r = ux * uy; hi = 1'b1; e.lat = 33; end
      DIV, REM: begin
        if (y == 0) r = (o == DIV) ? '1 : ux;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = (o == DIV) ? ux : 64'd0;
        else begin r = (o == DIV) ? sx / sy : sx % sy; e.lat = 33; end
      end
      DIVU, REMU: begin
        if (y == 0) r = (o == DIVU) ? '1 : ux;
        else begin r = (o == DIVU) ? ux / uy : ux % uy; e.lat = 33; end
      end
      default: begin r = '0; e.ill = 1'b1; end
    endcase
    e.res = hi ? r[63:32] : r[31:0];
    return e;
  endfunction

  task automatic addv(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] r, input int l, input logic [3:0] f);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.res = r; v.lat = l; v.fl = f;
    vq.push_back(v);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    int w = 0;
    exp_t e;
    op = o; a = x; b = y; in_valid = 1'b1;
    do begin
      @(negedge clk);
      w++;
    end while (!(in_ready && !flush) && w < 200);
    if (in_ready && !flush) begin
      e = model(o, x, y);
      e.acc_edge = edges + 1;
      exp_q.push_back(e);
    end else begin
      chk("issue_timeout", 64'(w), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom(); b = $urandom(); op = 5'($urandom_range(0, 31));
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    seen = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run16(input logic [4:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] r, input int l);
    int n = 1;
    chk("x16_in_ready", {63'b0, s_in_ready}, 64'd1);
    s_op = o; s_a = x; s_b = y; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    while (!s_out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("x16_latency", 64'(n), 64'(l));
    chk("x16_result", {48'b0, s_result}, {48'b0, r});
    @(posedge clk); #1;
  endtask

  initial forever @(posedge clk) edges++;

  // Compare process: every cycle out_valid is high, outputs must match the head
  // of the expectation queue; latency is checked on the first such cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {63'b0, out_valid}, 64'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", 64'(edges - exp_q[0].acc_edge + 1), 64'(exp_q[0].lat));
        end
        chk("result_flags", {28'b0, result, eq, lt, ltu, illegal},
            {28'b0, exp_q[0].res, exp_q[0].eq, exp_q[0].lt, exp_q[0].ltu, exp_q[0].ill});
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int w;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1; s_op = '0; s_a = '0; s_b = '0;

    addv(ADD,    32'hFFFFFFF0, 32'h4, 32'hFFFFFFF4, 1, 4'b0100);
    addv(SUB,    32'hFFFFFFF0, 32'h4, 32'hFFFFFFEC, 1, 4'b0100);
    addv(AND_,   32'hFFFFFFF0, 32'h4, 32'h00000000, 1, 4'b0100);
    addv(OR_,    32'hFFFFFFF0, 32'h4, 32'hFFFFFFF4, 1, 4'b0100);
    addv(XOR_,   32'hFFFFFFF0, 32'h4, 32'hFFFFFFF4, 1, 4'b0100);
    addv(SLT,    32'hFFFFFFF0, 32'h4, 32'h00000001, 1, 4'b0100);
    addv(SLL,    32'hFFFFFFF0, 32'h4, 32'hFFFFFF00, 1, 4'b0100);
    addv(SRL,    32'hFFFFFFF0, 32'h4, 32'h0FFFFFFF, 1, 4'b0100);
    addv(SRA,    32'hFFFFFFF0, 32'h4, 32'hFFFFFFFF, 1, 4'b0100);
    addv(SLTU,   32'hFFFFFFF0, 32'h4, 32'h00000000, 1, 4'b0100);
    addv(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, 4'b1000);
    addv(MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 33, 4'b1000);
    addv(MUL,    32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 33, 4'b0100);
    addv(MULHSU, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 33, 4'b0100);
    addv(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 4'b1000);
    addv(DIV,    32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33, 4'b0100);
    addv(REM,    32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33, 4'b0100);
    addv(DIV,    32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 4'b0010);
    addv(DIVU,   32'd100, 32'd7, 32'd14, 33, 4'b0000);
    addv(REMU,   32'd100, 32'd7, 32'd2, 33, 4'b0000);
    addv(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 4'b0110);
    addv(REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 4'b0110);
    addv(DIVU,   32'd5, 32'd0, 32'hFFFFFFFF, 1, 4'b0000);
    addv(REMU,   32'd5, 32'd0, 32'd5, 1, 4'b0000);
    addv(5'b11111, 32'd5, 32'd0, 32'd0, 1, 4'b0001);
    addv(5'b01010, 32'd1, 32'd1, 32'd0, 1, 4'b1001);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_result_flags", {27'b0, result, eq, lt, ltu, illegal, 1'b0}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Directed vectors, issued back to back
    foreach (vq[i]) begin
      e = model(vq[i].op, vq[i].a, vq[i].b);
      chk("model_res", {32'b0, e.res}, {32'b0, vq[i].res});
      chk("model_lat", 64'(e.lat), 64'(vq[i].lat));
      chk("model_flags", {60'b0, e.eq, e.lt, e.ltu, e.ill}, {60'b0, vq[i].fl});
      issue(vq[i].op, vq[i].a, vq[i].b);
    end
    drain();

    // Backpressure on a completed MUL, then a queued ADD taken on release
    out_ready = 1'b0;
    issue(MUL, 32'hFFFFFFFD, 32'h7);
    @(negedge clk);
    chk("busy_in_ready", {63'b0, in_ready}, 64'd0);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("bp_done_seen", {63'b0, out_valid}, 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
      chk("bp_result", {32'b0, result}, 64'hFFFFFFEB);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(ADD, 32'hFFFFFFF0, 32'h4);
    drain();

    // Flush at iteration 10 of a divide, with a competing offer
    issue(DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; op = ADD; a = 32'd1; b = 32'd2;
    @(posedge clk); #1;
    chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    repeat (40) @(negedge clk);
    chk("flush_quiet", {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;
    issue(ADD, 32'hFFFFFFF0, 32'h4);
    drain();

    // Asynchronous reset mid-multiply
    issue(MUL, 32'hFFFFFFFD, 32'h7);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_result_flags", {27'b0, result, eq, lt, ltu, illegal, 1'b0}, 64'd0);
    exp_q.delete();
    seen = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    issue(MUL, 32'hFFFFFFFD, 32'h7);
    drain();

    // XLEN=16 instance
    run16(MUL,   16'd300, 16'd300, 16'h5F90, 17);
    run16(MULHU, 16'd300, 16'd300, 16'h0001, 17);
    run16(ADD,   16'h7FFF, 16'h0001, 16'h8000, 1);
    run16(DIV,   16'h8000, 16'hFFFF, 16'h8000, 1);
    run16(REM,   16'hFFF9, 16'h0002, 16'hFFFF, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
